// File: rtl/mem_responder.sv
// Memory responder: registered CPU reads, edge-triggered CPU writes deferred behind loader writes.
// Optional build macro MEM_RESPONDER_PARITY_EN adds per-word even parity and the ld_perr input.
module mem_responder #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] addr,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata,
    input  logic              ld_en,
    input  logic [AWIDTH-1:0] ld_addr,
    input  logic [DWIDTH-1:0] ld_data,
`ifdef MEM_RESPONDER_PARITY_EN
    input  logic              ld_perr,
`endif
    output logic              wr_pending,
    output logic              proto_err
);

`ifdef MEM_RESPONDER_PARITY_EN
    localparam int MW = DWIDTH + 1;
`else
    localparam int MW = DWIDTH;
`endif

    typedef enum logic {IDLE, PEND} state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [DWIDTH-1:0] pend_data_q, pend_data_d;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              proto_err_q, proto_err_d;
    logic              wr_prev_q, wr_prev_d;

    logic [MW-1:0]     mem_q [0:(1<<AWIDTH)-1];

    logic              wr_edge, rd_go, fwd_hit;
    logic [MW-1:0]     rd_word;
    // Port A carries loader writes or the pending commit (never both); port B the new CPU write.
    logic              wa_en, wb_en;
    logic [AWIDTH-1:0] wa_addr, wb_addr;
    logic [MW-1:0]     wa_word, wb_word;

    function automatic logic [MW-1:0] make_word(input logic [DWIDTH-1:0] d);
`ifdef MEM_RESPONDER_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        rdata_d     = rdata_q;
        proto_err_d = proto_err_q;
        wr_prev_d   = mem_wr;
        wa_en       = ld_en;
        wa_addr     = ld_addr;
        wa_word     = make_word(ld_data);
`ifdef MEM_RESPONDER_PARITY_EN
        wa_word[DWIDTH] = wa_word[DWIDTH] ^ ld_perr;
`endif
        wb_en       = 1'b0;
        wb_addr     = addr;
        wb_word     = make_word(wdata);

        wr_edge = mem_wr & ~wr_prev_q;
        rd_go   = mem_rd & ~mem_wr;
        fwd_hit = (state_q == PEND) && (pend_addr_q == addr);
        rd_word = mem_q[addr];

        if (mem_rd && mem_wr) proto_err_d = 1'b1;

        if (rd_go) begin
            rdata_d = fwd_hit ? pend_data_q : rd_word[DWIDTH-1:0];
`ifdef MEM_RESPONDER_PARITY_EN
            if (!fwd_hit && (^rd_word)) proto_err_d = 1'b1;
`endif
        end

        case (state_q)
            IDLE: begin
                if (wr_edge) begin
                    if (ld_en) begin
                        pend_addr_d = addr;
                        pend_data_d = wdata;
                        state_d     = PEND;
                    end else begin
                        wb_en = 1'b1;
                    end
                end
            end
            PEND: begin
                if (ld_en) begin
                    if (wr_edge) begin
                        proto_err_d = 1'b1;
                        pend_addr_d = addr;
                        pend_data_d = wdata;
                    end
                end else begin
                    // Commit on port A; a new write on port B lands after it, so same address keeps the new data.
                    wa_en   = 1'b1;
                    wa_addr = pend_addr_q;
                    wa_word = make_word(pend_data_q);
                    wb_en   = wr_edge;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            rdata_q     <= '0;
            proto_err_q <= 1'b0;
            wr_prev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            rdata_q     <= rdata_d;
            proto_err_q <= proto_err_d;
            wr_prev_q   <= wr_prev_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wa_en) mem_q[wa_addr] <= wa_word;
            if (wb_en) mem_q[wb_addr] <= wb_word;
        end
    end

    assign rdata      = rdata_q;
    assign wr_pending = (state_q == PEND);
    assign proto_err  = proto_err_q;

endmodule
